// File: rtl/seg_pkg.sv
// Shared definitions for the 8-digit multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  function automatic logic [DIGIT_W-1:0] digit_of(
    input logic [NUM_DIGITS*DIGIT_W-1:0] word,
    input logic [2:0]                    idx
  );
    return word[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan: guard-blank then show each digit, with a
// one-entry load buffer that is committed to the display only at frame end.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  digit_en,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    sel_next;
  logic          sel_adv;
  logic [31:0]   active, active_next;
  logic [31:0]   pending;
  logic          pending_valid;
  logic          load_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      cnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sel   <= sel_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    sel_next   = sel;
    sel_adv    = 1'b0;
    unique case (state)
      ST_BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_next = ST_SHOW;
          cnt_next   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == CW'(TICK_DIV - 1)) begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          sel_next   = sel + 3'd1;
          sel_adv    = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    blank      = (state == ST_BLANK) || !digit_en[sel];
    frame_done = (state == ST_SHOW) && (cnt == CW'(TICK_DIV - 1)) && (sel == 3'd7);
    load_ready = !pending_valid;
  end

  assign load_acc    = load_valid && load_ready;
  // Swap happens only on the frame_done edge, which is also the sel 7->0 edge,
  // so num for digit 0 is taken from the freshly committed word.
  assign active_next = (frame_done && pending_valid) ? pending : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      active <= active_next;
      if (sel_adv)
        num <= digit_of(active_next, sel_next);
      if (load_acc) begin
        pending       <= load_data;
        pending_valid <= 1'b1;
      end else if (frame_done) begin
        pending_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl with TICK_DIV=4, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  localparam int unsigned SLOT  = 6;
  localparam int unsigned FRAME = 48;

  typedef struct packed {
    logic [3:0] num;
    logic [2:0] sel;
    logic       blank;
    logic       fd;
    logic       ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [7:0]  digit_en;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        frame_done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  exp_t        exp_q[$];
  logic [31:0] act_m, pend_m;
  logic        pv_m;
  int unsigned t;

  seg_scan_ctrl #(.TICK_DIV(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .digit_en   (digit_en),
    .num        (num),
    .sel        (sel),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    act_m = '0;
    pend_m = '0;
    pv_m = 1'b0;
    t = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".num"}, 32'(num), 32'h0);
    chk({tag, ".sel"}, 32'(sel), 32'h0);
    chk({tag, ".blank"}, 32'(blank), 32'h1);
    chk({tag, ".frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, ".load_ready"}, 32'(load_ready), 32'h1);
  endtask

  // One clock: predict the post-edge outputs, push, clock, pop and compare.
  task automatic step();
    exp_t        e;
    logic        fd_pre, acc;
    int unsigned p, s, ph;
    fd_pre = ((t % FRAME) == FRAME - 1);
    acc    = load_valid && !pv_m;
    if (fd_pre && pv_m) act_m = pend_m;
    if (acc) begin
      pend_m = load_data;
      pv_m   = 1'b1;
    end else if (fd_pre) begin
      pv_m = 1'b0;
    end
    t++;
    p  = t % FRAME;
    s  = p / SLOT;
    ph = p % SLOT;
    e.sel   = 3'(s);
    e.num   = act_m[4*s +: 4];
    e.blank = (ph < 2) || !digit_en[s];
    e.fd    = (p == FRAME - 1);
    e.ready = !pv_m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("num", 32'(num), 32'(e.num));
    chk("sel", 32'(sel), 32'(e.sel));
    chk("blank", 32'(blank), 32'(e.blank));
    chk("frame_done", 32'(frame_done), 32'(e.fd));
    chk("load_ready", 32'(load_ready), 32'(e.ready));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Offer a word and hold it until the model says it is taken (bounded).
  task automatic load_hold(input logic [31:0] d);
    logic acc;
    load_valid = 1'b1;
    load_data  = d;
    acc = 1'b0;
    for (int unsigned i = 0; i < 2 * FRAME && !acc; i++) begin
      acc = !pv_m;
      step();
    end
    load_valid = 1'b0;
    load_data  = $urandom;
    checks++;
    if (!acc) begin
      errors++;
      $error("FAIL load_accept_timeout: observed=0 expected=1");
    end
  endtask

  task automatic run_until_pos(input int unsigned pos);
    for (int unsigned i = 0; i < FRAME && (t % FRAME) != pos; i++) step();
  endtask

  initial begin
    int unsigned fd_cnt, last_fd, cyc;
    logic        seen5;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    digit_en   = 8'hFF;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Basic load: frame 1 shows zeros, frame 2 shows digit index values.
    load_valid = 1'b1;
    load_data  = 32'h7654_3210;
    step();
    load_valid = 1'b0;
    run(2 * FRAME);

    // Back-to-back loads: second waits for the frame_done edge.
    load_hold(32'h1111_1111);
    load_hold(32'h2222_2222);
    run(2 * FRAME);

    // Load exactly on the frame_done cycle goes to pending.
    run_until_pos(FRAME - 1);
    load_valid = 1'b1;
    load_data  = 32'hAAAA_AAAA;
    checks++;
    if (load_ready !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $error("FAIL fd_load_setup: observed ready=%0b fd=%0b expected ready=1 fd=1", load_ready, frame_done);
    end
    step();
    load_valid = 1'b0;
    run(2 * FRAME + 4);

    // Partial digit enable.
    digit_en = 8'h0F;
    run(FRAME);
    digit_en = 8'hFF;

    // Ten frames: count pulses and spacing.
    fd_cnt  = 0;
    last_fd = 0;
    for (cyc = 0; cyc < 10 * FRAME; cyc++) begin
      step();
      if (frame_done === 1'b1) begin
        if (fd_cnt != 0) chk("fd_spacing", cyc - last_fd, FRAME);
        chk("fd_sel7", 32'(sel), 32'h7);
        chk("fd_unblank", 32'(blank), 32'h0);
        fd_cnt++;
        last_fd = cyc;
      end
    end
    chk("fd_count", fd_cnt, 10);

    // Reset during ST_SHOW of sel=5 with pending full.
    load_hold(32'h5555_5555);
    run_until_pos(5 * SLOT + 3);
    chk("pre_rst_ready", 32'(load_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    model_reset();
    seen5 = 1'b0;
    for (int unsigned i = 0; i < 2 * FRAME; i++) begin
      step();
      if (num === 4'h5) seen5 = 1'b1;
    end
    chk("discarded_pending", 32'(seen5), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
